// File: rtl/logic_proc_control.sv
// logic_proc_control: sequencer for the 8-bit bit-serial logic processor.
// Turns the held execute/loadA/loadB buttons into register load strobes and
// exactly WIDTH shift strobes per operation, then parks in HALT until execute
// is released.
// Build option: define LOGIC_PROC_SINGLE_STEP_EN to single-step the shifts,
// one full execute press per shift_en cycle.
module logic_proc_control #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             execute,
    input  logic             load_a_req,
    input  logic             load_b_req,
    output logic             shift_en,
    output logic             ld_a,
    output logic             ld_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] shift_cnt
);

`ifdef LOGIC_PROC_SINGLE_STEP_EN
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT     = 2'd1,
        HALT      = 2'd2,
        STEP_WAIT = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HALT  = 2'd2
    } state_t;
`endif

    // Count value seen during the final shift cycle of an operation.
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
`ifdef LOGIC_PROC_SINGLE_STEP_EN
    // Set once execute has been seen low in STEP_WAIT; the next high level
    // then completes the press and releases one more shift.
    logic             armed_q, armed_d;
`endif

    // Next-state, shift counter and done-pulse decisions.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`ifdef LOGIC_PROC_SINGLE_STEP_EN
        armed_d = armed_q;
`endif
        case (state_q)
            IDLE: begin
                if (execute) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                end
            end
            SHIFT: begin
                // execute is deliberately ignored: an operation always runs
                // to completion once started.
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else begin
`ifdef LOGIC_PROC_SINGLE_STEP_EN
                    state_d = STEP_WAIT;
                    armed_d = 1'b0;
`endif
                end
            end
            HALT: begin
                if (!execute) state_d = IDLE;
            end
`ifdef LOGIC_PROC_SINGLE_STEP_EN
            STEP_WAIT: begin
                if (!execute) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = SHIFT;
                    armed_d = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State, counter and done pulse; reset forces everything back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
`ifdef LOGIC_PROC_SINGLE_STEP_EN
            armed_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
`ifdef LOGIC_PROC_SINGLE_STEP_EN
            armed_q <= armed_d;
`endif
        end
    end

    // Strobes; loads lose to execute and are only honoured while idle.
    always_comb begin
        shift_en  = ~reset & (state_q == SHIFT);
        busy      = ~reset & (state_q != IDLE);
        ld_a      = ~reset & load_a_req & (state_q == IDLE) & ~execute;
        ld_b      = ~reset & load_b_req & (state_q == IDLE) & ~execute;
        done      = done_q;
        shift_cnt = cnt_q;
    end

endmodule
